wide_addsub_seq: RTL and testbench

- Parametrised multi-cycle add/subtract unit for wide multiprecision operands, used by the modular-arithmetic datapath (Montgomery/RSA).
- Succeeds the single-shot fixed 514-bit adder: the width is now a parameter, and the carry chain is split into LIMB-bit slices processed one per cycle to meet timing at large WIDTH.
- Start/done handshake plus a busy flag; result is held stable until the next accepted start.

---
 rtl/wide_addsub_pkg.sv | 24 ++
 rtl/addsub_limb.sv | 23 ++
 rtl/wide_addsub_seq.sv | 109 ++++++++++
 tb/tb_wide_addsub_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wide_addsub_pkg.sv
`default_nettype none
// ==========================================================================
// wide_addsub_pkg: shared state encoding and sizing helpers for wide_addsub_seq
// Revision: 1.0
// ==========================================================================
package wide_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice count covers WIDTH+1 bits so the add carry-out has a home.
  function automatic int nlimb(input int width, input int limb);
    return (width + limb) / limb;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_limb.sv
`default_nettype none
// ==========================================================================
// addsub_limb: combinational LIMB-bit adder with carry in/out and B inversion
// Revision: 1.0
// ==========================================================================
module addsub_limb #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            cin,
  input  logic            invert_b,
  output logic [LIMB-1:0] sum,
  output logic            cout
);

  logic [LIMB-1:0] w_b_eff;

  assign w_b_eff     = invert_b ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{LIMB{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/wide_addsub_seq.sv
`default_nettype none
// ==========================================================================
// wide_addsub_seq: multi-cycle wide add/subtract, one LIMB slice per cycle
// Revision: 1.0
// ==========================================================================
module wide_addsub_seq
  import wide_addsub_pkg::*;
#(
  parameter int WIDTH = 514,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done
);

  localparam int c_NLIMB = nlimb(WIDTH, LIMB);
  localparam int c_PW    = c_NLIMB * LIMB;
  localparam int c_IW    = idx_width(c_NLIMB);
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NLIMB - 1);

  state_t            r_state;
  logic [c_PW-1:0]   r_a;
  logic [c_PW-1:0]   r_b;
  logic              r_sub;
  logic              r_carry;
  logic [c_IW-1:0]   r_idx;
  logic [WIDTH:0]    r_res;
  logic              r_busy;
  logic              r_done;

  logic [LIMB-1:0]   w_sum;
  logic              w_cout;
  logic [WIDTH:0]    w_res_next;

  // Operands shift down one slice per cycle, so the adder always sees bits [LIMB-1:0].
  addsub_limb #(
    .LIMB(LIMB)
  ) u_limb (
    .a        (r_a[LIMB-1:0]),
    .b        (r_b[LIMB-1:0]),
    .cin      (r_carry),
    .invert_b (r_sub),
    .sum      (w_sum),
    .cout     (w_cout)
  );

  // Padding bits of the top slice have no result bit and are simply dropped.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_res_bit
    assign w_res_next[i] = (r_idx == c_IW'(i / LIMB)) ? w_sum[i % LIMB] : r_res[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= {{(c_PW - WIDTH){1'b0}}, in_a};
            r_b     <= {{(c_PW - WIDTH){1'b0}}, in_b};
            r_sub   <= subtract;
            r_carry <= subtract;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_a     <= r_a >> LIMB;
          r_b     <= r_b >> LIMB;
          r_idx   <= r_idx + c_IW'(1);
          if (r_idx == c_LAST_IDX) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result = r_res;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wide_addsub_seq.sv
`default_nettype none
// ==========================================================================
// tb_wide_addsub_seq: directed checks of the 514/64 build plus an exhaustive 8/3 sweep
// Revision: 1.0
// ==========================================================================
module tb_wide_addsub_seq;

  localparam int c_W  = 514;
  localparam int c_SW = 8;
  localparam int c_NS = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic           big_start;
  logic           big_sub;
  logic [c_W-1:0] big_a;
  logic [c_W-1:0] big_b;
  logic [c_W:0]   big_res;
  logic           big_busy;
  logic           big_done;

  logic            s_start;
  logic            s_sub;
  logic [c_SW-1:0] s_b;
  logic [c_SW-1:0] s_a   [c_NS];
  logic [c_SW:0]   s_res [c_NS];
  logic [c_NS-1:0] s_busy;
  logic [c_NS-1:0] s_done;

  int n_checks = 0;
  int n_errors = 0;

  wide_addsub_seq #(.WIDTH(c_W), .LIMB(64)) u_big (
    .clk      (clk),
    .resetn   (resetn),
    .start    (big_start),
    .subtract (big_sub),
    .in_a     (big_a),
    .in_b     (big_b),
    .result   (big_res),
    .busy     (big_busy),
    .done     (big_done)
  );

  for (genvar k = 0; k < c_NS; k++) begin : g_small
    wide_addsub_seq #(.WIDTH(c_SW), .LIMB(3)) u_small (
      .clk      (clk),
      .resetn   (resetn),
      .start    (s_start),
      .subtract (s_sub),
      .in_a     (s_a[k]),
      .in_b     (s_b),
      .result   (s_res[k]),
      .busy     (s_busy[k]),
      .done     (s_done[k])
    );
  end

  task automatic check(input string tag, input logic [519:0] got, input logic [519:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // One operation on the wide unit: latency, result, then return to idle.
  task automatic run_big(input string tag, input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         input logic sub, input logic [c_W:0] expv);
    int cyc;
    @(negedge clk);
    big_a     = a;
    big_b     = b;
    big_sub   = sub;
    big_start = 1'b1;
    @(posedge clk);
    #1;
    big_start = 1'b0;
    big_a     = ~a;
    big_b     = ~b;
    big_sub   = ~sub;
    check({tag, "_busy"}, 520'(big_busy), 520'(1));
    cyc = 0;
    while (!big_done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, 520'(cyc), 520'(9));
    check({tag, "_res"}, 520'(big_res), 520'(expv));
    @(posedge clk);
    #1;
    check({tag, "_idle"}, 520'({big_busy, big_done}), 520'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [c_W:0]    hres;
    logic [c_W-1:0]  ones;
    logic [c_SW:0]   sexp;
    ones      = '1;
    resetn    = 1'b0;
    big_start = 1'b0;
    big_sub   = 1'b0;
    big_a     = '0;
    big_b     = '0;
    s_start   = 1'b0;
    s_sub     = 1'b0;
    s_b       = '0;
    for (int k = 0; k < c_NS; k++) s_a[k] = '0;
    #1;
    check("rst_res", 520'(big_res), 520'(0));
    check("rst_flags", 520'({big_busy, big_done}), 520'(0));
    #20;
    @(negedge clk);
    resetn = 1'b1;

    run_big("add_full", ones, ones, 1'b0, {{514{1'b1}}, 1'b0});
    run_big("sub_zero", ones, ones, 1'b1, '0);
    run_big("sub_borrow", '0, 514'(1), 1'b1, {515{1'b1}});
    run_big("add_x64", 514'((515'(1) << 64) - 515'(1)), 514'(1), 1'b0, 515'(1) << 64);
    run_big("sub_x128", 514'(515'(1) << 128), 514'(1), 1'b1, (515'(1) << 128) - 515'(1));
    run_big("add_msb", 514'(515'(1) << 513), 514'(515'(1) << 513), 1'b0, 515'(1) << 514);

    // Asynchronous reset part-way through an operation
    @(negedge clk);
    big_a = ones; big_b = ones; big_sub = 1'b0; big_start = 1'b1;
    @(posedge clk);
    #1;
    big_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("midrst_res", 520'(big_res), 520'(0));
    check("midrst_flags", 520'({big_busy, big_done}), 520'(0));
    @(negedge clk);
    resetn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (big_done) ndone++;
    end
    check("norst_done", 520'(ndone), 520'(0));

    // start held through RUN and DONE with changing operands
    @(negedge clk);
    big_a = 514'(12345); big_b = 514'(515'(1) << 200); big_sub = 1'b0; big_start = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    hres  = '0;
    for (int c = 1; c <= 14; c++) begin
      big_start = (c <= 10);
      big_a     = ones >> c;
      big_b     = 514'(c * 7);
      big_sub   = c[0];
      @(posedge clk);
      #1;
      if (big_done) begin
        ndone++;
        hres = big_res;
      end
    end
    big_start = 1'b0;
    check("hs_ndone", 520'(ndone), 520'(1));
    check("hs_res", 520'(hres), 520'((515'(1) << 200) + 515'(12345)));
    check("hs_idle", 520'(big_busy), 520'(0));

    // Exhaustive 8-bit sweep, 16 units in parallel split on a[7:4]
    for (int sub = 0; sub < 2; sub++) begin
      for (int b = 0; b < 256; b++) begin
        for (int lo = 0; lo < 16; lo++) begin
          @(negedge clk);
          s_sub = sub[0];
          s_b   = b[7:0];
          for (int k = 0; k < c_NS; k++) s_a[k] = {k[3:0], lo[3:0]};
          s_start = 1'b1;
          @(posedge clk);
          #1;
          s_start = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          for (int k = 0; k < c_NS; k++) begin
            if (sub[0]) sexp = {1'b0, k[3:0], lo[3:0]} - {1'b0, b[7:0]};
            else        sexp = {1'b0, k[3:0], lo[3:0]} + {1'b0, b[7:0]};
            check("small", 520'({s_done[k], s_res[k]}), 520'({1'b1, sexp}));
          end
          @(posedge clk);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
